// File: rtl/fir_mac_seq_pkg.sv
// rtl/fir_mac_seq_pkg.sv - shared widths, FSM states and saturating arithmetic for the FIR MAC
// Arithmetic helpers work in CALC_W bits so one definition serves every instance width.
package fir_pkg;

    localparam int DEF_DATA_W = 3;
    localparam int DEF_COEF_W = 16;
    localparam int DEF_TAPS   = 10;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_OUT_W  = 16;
    localparam int DEF_SHIFT  = 0;
    localparam int CALC_W     = 64;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [CALC_W-1:0] val;
        logic              ovf;
    } sat_t;

    function automatic sat_t clamp_to(input logic signed [CALC_W-1:0] v, input int w);
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        sat_t r;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        r.val = v;
        r.ovf = 1'b0;
        if (v > hi) begin
            r.val = hi;
            r.ovf = 1'b1;
        end else if (v < lo) begin
            r.val = lo;
            r.ovf = 1'b1;
        end
        return r;
    endfunction

    // Operands are sign-extended to CALC_W, so the exact sum never wraps before the clamp.
    function automatic sat_t sat_add(input logic signed [CALC_W-1:0] a,
                                     input logic signed [CALC_W-1:0] b,
                                     input int w);
        return clamp_to(a + b, w);
    endfunction

    function automatic sat_t round_shift_sat(input logic signed [CALC_W-1:0] acc,
                                             input int shift,
                                             input int out_w);
        logic signed [CALC_W-1:0] r;
        r = acc;
        if (shift > 0) r = r + (64'sd1 <<< (shift - 1));
        r = r >>> shift;
        return clamp_to(r, out_w);
    endfunction

endpackage

// File: rtl/fir_mac_seq_if.sv
// rtl/fir_mac_seq_if.sv - control, SpSram read and result signals of the FIR MAC engine
interface fir_mac_seq_if import fir_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int TAPS   = DEF_TAPS,
    parameter int OUT_W  = DEF_OUT_W
);
    localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;

    logic                     iStart;
    logic                     iAbort;
    logic [AW-1:0]            oAddr;
    logic                     oRdEn;
    logic signed [DATA_W-1:0] iDelay;
    logic signed [COEF_W-1:0] iCoeff;
    logic signed [OUT_W-1:0]  oMac;
    logic                     oValid;
    logic                     oBusy;
    logic                     oOvf;

    modport master (output iStart, iAbort, iDelay, iCoeff,
                    input  oAddr, oRdEn, oMac, oValid, oBusy, oOvf);
    modport slave  (input  iStart, iAbort, iDelay, iCoeff,
                    output oAddr, oRdEn, oMac, oValid, oBusy, oOvf);
endinterface

// File: rtl/fir_mac_seq_outsat.sv
// rtl/fir_mac_seq_outsat.sv - round half up, arithmetic shift and saturate ACC_W to OUT_W
module fir_mac_outsat import fir_pkg::*; #(
    parameter int ACC_W = DEF_ACC_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic signed [OUT_W-1:0] o_mac,
    output logic                    o_clamp
);
    sat_t w_res;
    logic w_unused;

    always_comb begin
        w_res   = round_shift_sat({{(CALC_W-ACC_W){i_acc[ACC_W-1]}}, i_acc}, SHIFT, OUT_W);
        o_mac   = w_res.val[OUT_W-1:0];
        o_clamp = w_res.ovf;
    end

    assign w_unused = ^w_res.val[CALC_W-1:OUT_W];
endmodule

// File: rtl/fir_mac_seq.sv
// rtl/fir_mac_seq.sv - sequential TAPS-tap MAC: address walk, product/accumulate pipe, output stage
module fir_mac_seq import fir_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int TAPS   = DEF_TAPS,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int SHIFT  = DEF_SHIFT
) (
    input logic          iClk12M,
    input logic          iRsn,
    fir_mac_seq_if.slave bus
);
    localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int PW = DATA_W + COEF_W;
    localparam logic [AW-1:0] LAST_ADDR = AW'(TAPS - 1);

    state_t r_state, w_state_nxt;
    logic w_start, w_abort, w_last, w_add_ovf, w_clamp, w_unused;
    logic [AW-1:0] r_addr;
    logic r_rden, r_rd_d, r_v1, r_ovf_acc, r_busy, r_valid, r_ovf;
    logic signed [PW-1:0] r_prod, w_dext, w_cext, w_prod;
    logic signed [ACC_W-1:0] r_acc, w_sum;
    logic signed [OUT_W-1:0] r_mac, w_mac;
    sat_t w_add;

    assign w_abort = bus.iAbort && (r_state != IDLE);
    assign w_last  = (r_addr == LAST_ADDR);

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        if (w_abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:  if (bus.iStart && !bus.iAbort) begin
                           w_state_nxt = RUN;
                           w_start     = 1'b1;
                       end
                RUN:   if (w_last) w_state_nxt = DRAIN;
                // The last product is still in r_v1 here; it lands in the acc on the DONE edge.
                DRAIN: if (!r_rd_d) w_state_nxt = DONE;
                DONE:  w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_dext    = {{COEF_W{bus.iDelay[DATA_W-1]}}, bus.iDelay};
        w_cext    = {{DATA_W{bus.iCoeff[COEF_W-1]}}, bus.iCoeff};
        w_prod    = w_dext * w_cext;
        w_add     = sat_add({{(CALC_W-ACC_W){r_acc[ACC_W-1]}}, r_acc},
                            {{(CALC_W-PW){r_prod[PW-1]}}, r_prod}, ACC_W);
        w_sum     = w_add.val[ACC_W-1:0];
        w_add_ovf = w_add.ovf;
    end

    assign w_unused = ^w_add.val[CALC_W-1:ACC_W];

    fir_mac_outsat #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_outsat (
        .i_acc   (r_acc),
        .o_mac   (w_mac),
        .o_clamp (w_clamp)
    );

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_rden    <= 1'b0;
            r_rd_d    <= 1'b0;
            r_v1      <= 1'b0;
            r_prod    <= '0;
            r_acc     <= '0;
            r_ovf_acc <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_mac     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (r_state != IDLE) && !w_abort;
            r_valid <= 1'b0;
            if (w_abort) begin
                r_addr    <= '0;
                r_rden    <= 1'b0;
                r_rd_d    <= 1'b0;
                r_v1      <= 1'b0;
                r_acc     <= '0;
                r_ovf_acc <= 1'b0;
            end else begin
                r_rd_d <= r_rden;
                r_v1   <= r_rd_d;
                if (r_rd_d) r_prod <= w_prod;
                if (w_start) begin
                    r_addr    <= '0;
                    r_rden    <= 1'b1;
                    r_acc     <= '0;
                    r_ovf_acc <= 1'b0;
                end else if (r_state == RUN) begin
                    if (w_last) begin
                        r_addr <= '0;
                        r_rden <= 1'b0;
                    end else begin
                        r_addr <= r_addr + AW'(1);
                    end
                end
                if (r_v1) begin
                    r_acc     <= w_sum;
                    r_ovf_acc <= r_ovf_acc | w_add_ovf;
                end
                if (r_state == DONE) begin
                    r_valid <= 1'b1;
                    r_mac   <= w_mac;
                    r_ovf   <= w_clamp | r_ovf_acc;
                end
            end
        end
    end

    assign bus.oAddr  = r_addr;
    assign bus.oRdEn  = r_rden;
    assign bus.oMac   = r_mac;
    assign bus.oValid = r_valid;
    assign bus.oBusy  = r_busy;
    assign bus.oOvf   = r_ovf;
endmodule

// File: tb/tb_fir_mac_seq.sv
// tb/tb_fir_mac_seq.sv - directed vector table plus abort/restart/reset sequences for fir_mac_seq
module tb_fir_mac_seq;

    typedef struct {
        int d;
        int taps;
        int dly;
        int cf;
        int mac;
        int ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] tb_start = '0;
    logic tb_abort = 1'b0;
    logic signed [2:0] tb_dly = '0;
    logic signed [15:0] tb_cf = '0;
    int checks = 0;
    int errors = 0;

    int   w_mac [3];
    int   w_addr [3];
    logic w_valid [3];
    logic w_busy [3];
    logic w_rden [3];
    logic w_ovf [3];

    always #5 clk = ~clk;

    fir_mac_seq_if #(.TAPS(10)) if_def ();
    fir_mac_seq_if #(.TAPS(10)) if_a18 ();
    fir_mac_seq_if #(.TAPS(2))  if_t2 ();

    fir_mac_seq #(.TAPS(10))              u_def (.iClk12M(clk), .iRsn(rst_n), .bus(if_def));
    fir_mac_seq #(.TAPS(10), .ACC_W(18))  u_a18 (.iClk12M(clk), .iRsn(rst_n), .bus(if_a18));
    fir_mac_seq #(.TAPS(2), .SHIFT(2))    u_t2  (.iClk12M(clk), .iRsn(rst_n), .bus(if_t2));

    assign if_def.iStart = tb_start[0];
    assign if_a18.iStart = tb_start[1];
    assign if_t2.iStart  = tb_start[2];
    assign if_def.iAbort = tb_abort;
    assign if_a18.iAbort = 1'b0;
    assign if_t2.iAbort  = 1'b0;
    assign if_def.iDelay = tb_dly;
    assign if_a18.iDelay = tb_dly;
    assign if_t2.iDelay  = tb_dly;
    assign if_def.iCoeff = tb_cf;
    assign if_a18.iCoeff = tb_cf;
    assign if_t2.iCoeff  = tb_cf;

    assign w_mac[0] = int'(if_def.oMac);
    assign w_mac[1] = int'(if_a18.oMac);
    assign w_mac[2] = int'(if_t2.oMac);
    assign w_addr[0] = int'(if_def.oAddr);
    assign w_addr[1] = int'(if_a18.oAddr);
    assign w_addr[2] = int'(if_t2.oAddr);
    assign w_valid[0] = if_def.oValid;
    assign w_valid[1] = if_a18.oValid;
    assign w_valid[2] = if_t2.oValid;
    assign w_busy[0] = if_def.oBusy;
    assign w_busy[1] = if_a18.oBusy;
    assign w_busy[2] = if_t2.oBusy;
    assign w_rden[0] = if_def.oRdEn;
    assign w_rden[1] = if_a18.oRdEn;
    assign w_rden[2] = if_t2.oRdEn;
    assign w_ovf[0] = if_def.oOvf;
    assign w_ovf[1] = if_a18.oOvf;
    assign w_ovf[2] = if_t2.oOvf;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns at 1 time unit after the edge that samples iStart (E0).
    task automatic pulse(input int d);
        tb_start[d] = 1'b1;
        step();
        tb_start[d] = 1'b0;
    endtask

    task automatic watch(input int d, input int n0, input int ncyc, output int first, output int cnt);
        first = -1;
        cnt   = 0;
        for (int n = n0 + 1; n <= n0 + ncyc; n++) begin
            step();
            if (w_valid[d]) begin
                cnt++;
                if (first < 0) first = n;
            end
        end
    endtask

    task automatic run_sample(input int d, input int taps, output int lat, output int mac,
                              output int ovf, output int addr_ok, output int busy_ok);
        lat = -1; mac = 0; ovf = 0; addr_ok = 1; busy_ok = 1;
        pulse(d);
        if (w_addr[d] != 0 || !w_rden[d]) addr_ok = 0;
        if (w_busy[d]) busy_ok = 0;
        for (int n = 1; n <= 3 * taps + 10; n++) begin
            step();
            if (n < taps && (w_addr[d] != n || !w_rden[d])) addr_ok = 0;
            if (n >= taps && w_rden[d]) addr_ok = 0;
            if (!w_busy[d]) busy_ok = 0;
            if (w_valid[d]) begin
                lat = n;
                mac = w_mac[d];
                ovf = int'(w_ovf[d]);
                break;
            end
        end
        step();
        if (w_busy[d] || w_valid[d]) busy_ok = 0;
    endtask

    initial begin
        vec_t vecs [8];
        int lat, mac, ovf, aok, bok, first, cnt;
        vecs[0] = '{0, 10,  3,     1,     30, 0};
        vecs[1] = '{0, 10,  3, 32767,  32767, 1};
        vecs[2] = '{0, 10, -4, 32767, -32768, 1};
        vecs[3] = '{1, 10,  3, 32767,  32767, 1};
        vecs[4] = '{2,  2,  3,     1,      2, 0};
        vecs[5] = '{2,  2, -3,     1,     -1, 0};
        vecs[6] = '{2,  2, -1,     1,      0, 0};
        vecs[7] = '{0, 10, -3,     1,    -30, 0};

        repeat (3) step();
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_mac_%0d", d), w_mac[d], 0);
            check($sformatf("rst_addr_%0d", d), w_addr[d], 0);
            check($sformatf("rst_ctl_%0d", d),
                  int'({w_valid[d], w_busy[d], w_rden[d], w_ovf[d]}), 0);
        end
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            tb_dly = 3'(vecs[i].dly);
            tb_cf  = 16'(vecs[i].cf);
            run_sample(vecs[i].d, vecs[i].taps, lat, mac, ovf, aok, bok);
            check($sformatf("v%0d_latency", i), lat, vecs[i].taps + 3);
            check($sformatf("v%0d_mac", i), mac, vecs[i].mac);
            check($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
            check($sformatf("v%0d_addr_seq", i), aok, 1);
            check($sformatf("v%0d_busy", i), bok, 1);
        end

        // Abort in RUN while address 4 is on the bus.
        tb_dly = 3'sd3;
        tb_cf  = 16'sd1;
        pulse(0);
        repeat (4) step();
        check("abort_addr", w_addr[0], 4);
        tb_abort = 1'b1;
        step();
        tb_abort = 1'b0;
        check("abort_busy", int'(w_busy[0]), 0);
        check("abort_rden", int'(w_rden[0]), 0);
        watch(0, 5, 20, first, cnt);
        check("abort_no_valid", cnt, 0);
        run_sample(0, 10, lat, mac, ovf, aok, bok);
        check("post_abort_mac", mac, 30);
        check("post_abort_latency", lat, 13);
        check("post_abort_ovf", ovf, 0);

        // Second start during RUN must not spawn another sample.
        pulse(0);
        repeat (3) step();
        tb_start[0] = 1'b1;
        step();
        tb_start[0] = 1'b0;
        watch(0, 4, 30, first, cnt);
        check("run_start_first", first, 13);
        check("run_start_count", cnt, 1);

        // Start held during the DONE cycle is ignored.
        pulse(0);
        repeat (12) step();
        tb_start[0] = 1'b1;
        step();
        tb_start[0] = 1'b0;
        check("done_valid", int'(w_valid[0]), 1);
        watch(0, 13, 20, first, cnt);
        check("done_start_ignored", cnt, 0);

        // Back-to-back: start in the oValid cycle is accepted on the next edge.
        pulse(0);
        repeat (13) step();
        check("b2b_valid1", int'(w_valid[0]), 1);
        check("b2b_mac1", w_mac[0], 30);
        tb_start[0] = 1'b1;
        tb_dly = -3'sd3;
        step();
        tb_start[0] = 1'b0;
        watch(0, 14, 30, first, cnt);
        check("b2b_second_edge", first, 27);
        check("b2b_count", cnt, 1);
        check("b2b_mac2", w_mac[0], -30);

        // Asynchronous reset in DRAIN.
        tb_dly = 3'sd3;
        pulse(0);
        repeat (11) step();
        check("drain_busy", int'(w_busy[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_mac", w_mac[0], 0);
        check("async_rst_ctl", int'({w_valid[0], w_busy[0], w_rden[0], w_ovf[0]}), 0);
        #1 rst_n = 1'b1;
        step();
        watch(0, 0, 10, first, cnt);
        check("async_rst_discard", cnt, 0);
        run_sample(0, 10, lat, mac, ovf, aok, bok);
        check("post_rst_mac", mac, 30);
        check("post_rst_latency", lat, 13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
